kv_cmd_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the key-value store core. It buffers key-value commands from a simple valid/ready producer (pin bridge or firmware-facing logic) in a small FIFO. Each command is issued as a single Wishbone-style strobe/ack transaction to the core, and the core's returned data and duplicate flag are captured into a one-entry response register for a valid/ready consumer. A per-transaction timeout guarantees forward progress if the core never acknowledges.

---
 rtl/kv_cmd_sequencer.sv | 160 ++++++++++++++++
 tb/tb_kv_cmd_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kv_cmd_sequencer.sv
// rtl/kv_cmd_sequencer.sv - buffered strobe/ack command issuer for the key-value core
module kv_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst_1,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic        cmd_adr_is_key,
  input  logic        cmd_dat_is_key,
  input  logic [15:0] cmd_adr,
  input  logic [15:0] cmd_dat,
  output logic        STB_o,
  output logic        CYC_o,
  output logic        WE_o,
  output logic        ADR_IS_KEY_o,
  output logic        DAT_IS_KEY_o,
  output logic [15:0] ADR_o,
  output logic [15:0] DAT_o,
  input  logic        ACK_i,
  input  logic [15:0] DAT_i,
  input  logic        DUP_i,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_dat,
  output logic        rsp_dup,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 35;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [9:0]  TO_LAST  = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  state_t        r_state;
  logic [9:0]    r_to_cnt;
  logic          r_stb;
  logic          r_we;
  logic          r_adr_is_key;
  logic          r_dat_is_key;
  logic [15:0]   r_adr;
  logic [15:0]   r_dat;
  logic          r_rsp_valid;
  logic [15:0]   r_rsp_dat;
  logic          r_rsp_dup;
  logic          r_rsp_timeout;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = cmd_valid && !w_full;
  // Issue only once the previous response has been consumed: one transaction in flight.
  assign w_pop   = (r_state == S_IDLE) && !w_empty && !r_rsp_valid;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_we, cmd_adr_is_key, cmd_dat_is_key, cmd_adr, cmd_dat};
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst_1) begin
    if (sys_rst_1) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst_1) begin
    if (sys_rst_1) begin
      r_state       <= S_IDLE;
      r_to_cnt      <= '0;
      r_stb         <= 1'b0;
      r_we          <= 1'b0;
      r_adr_is_key  <= 1'b0;
      r_dat_is_key  <= 1'b0;
      r_adr         <= '0;
      r_dat         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_dat     <= '0;
      r_rsp_dup     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_we, r_adr_is_key, r_dat_is_key, r_adr, r_dat} <= w_head;
            r_stb    <= 1'b1;
            r_to_cnt <= '0;
            r_state  <= S_BUS;
          end
        end
        S_BUS: begin
          if (ACK_i) begin
            r_rsp_dat     <= DAT_i;
            r_rsp_dup     <= DUP_i;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_stb         <= 1'b0;
            r_state       <= S_RESP;
          end else if (r_to_cnt == TO_LAST) begin
            r_rsp_dat     <= '0;
            r_rsp_dup     <= 1'b0;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_stb         <= 1'b0;
            r_state       <= S_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + 10'd1;
          end
        end
        S_RESP: begin
          if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready    = !w_full;
  assign STB_o        = r_stb;
  assign CYC_o        = r_stb;
  assign WE_o         = r_we;
  assign ADR_IS_KEY_o = r_adr_is_key;
  assign DAT_IS_KEY_o = r_dat_is_key;
  assign ADR_o        = r_adr;
  assign DAT_o        = r_dat;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_dat      = r_rsp_dat;
  assign rsp_dup      = r_rsp_dup;
  assign rsp_timeout  = r_rsp_timeout;
  assign busy         = !w_empty || (r_state != S_IDLE) || r_rsp_valid;

endmodule

// File: tb/tb_kv_cmd_sequencer.sv
// tb/tb_kv_cmd_sequencer.sv - scoreboard bench for kv_cmd_sequencer
module tb_kv_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst_1 = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_adr_is_key, cmd_dat_is_key;
  logic [15:0] cmd_adr, cmd_dat;
  logic        STB_o, CYC_o, WE_o, ADR_IS_KEY_o, DAT_IS_KEY_o;
  logic [15:0] ADR_o, DAT_o;
  logic        ACK_i, DUP_i;
  logic [15:0] DAT_i;
  logic        rsp_valid, rsp_ready, rsp_dup, rsp_timeout, busy;
  logic [15:0] rsp_dat;

  always #5 sys_clk = ~sys_clk;

  kv_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_1(sys_rst_1),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr_is_key(cmd_adr_is_key), .cmd_dat_is_key(cmd_dat_is_key),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .STB_o(STB_o), .CYC_o(CYC_o), .WE_o(WE_o), .ADR_IS_KEY_o(ADR_IS_KEY_o),
    .DAT_IS_KEY_o(DAT_IS_KEY_o), .ADR_o(ADR_o), .DAT_o(DAT_o),
    .ACK_i(ACK_i), .DAT_i(DAT_i), .DUP_i(DUP_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_dup(rsp_dup), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  // d = STB-high cycle in which the core model acks; d > TO means it never does.
  typedef struct {
    logic        we, ak, dk;
    logic [15:0] adr, dat;
    int          d;
    logic [15:0] rdat;
    logic        rdup;
  } plan_t;
  typedef struct {
    logic [15:0] dat;
    logic        dup, to;
  } rsp_t;

  plan_t plan_q[$];
  rsp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    rsp_mode = 0;
  bit    late_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  initial begin : core_model
    bit    in_trans = 1'b0;
    int    k = 0;
    plan_t p;
    p.we = 0; p.ak = 0; p.dk = 0; p.adr = 0; p.dat = 0; p.d = 1; p.rdat = 0; p.rdup = 0;
    forever begin
      @(negedge sys_clk); #1;
      if (sys_rst_1) begin
        in_trans = 1'b0;
        k = 0;
        ACK_i = 1'b0;
      end else if (STB_o) begin
        if (!in_trans) begin
          if (plan_q.size() == 0) check("unexpected_stb", 1, 0);
          else p = plan_q.pop_front();
          in_trans = 1'b1;
          k = 0;
        end
        k++;
        check("bus_adr", ADR_o, p.adr);
        check("bus_dat", DAT_o, p.dat);
        check("bus_ctl", {WE_o, ADR_IS_KEY_o, DAT_IS_KEY_o, CYC_o}, {p.we, p.ak, p.dk, 1'b1});
        if (k > TO) check("stb_overrun", k, TO);
        ACK_i = (k == p.d);
        DAT_i = (k == p.d) ? p.rdat : 16'($urandom);
        DUP_i = (k == p.d) ? p.rdup : 1'($urandom);
      end else begin
        if (in_trans) begin
          check("stb_width", k, (p.d < TO) ? p.d : TO);
          check("cyc_low", CYC_o, 0);
          in_trans = 1'b0;
        end
        ACK_i = late_ack ? 1'b1 : 1'($urandom_range(0, 1));
        DAT_i = 16'($urandom);
        DUP_i = 1'($urandom);
      end
    end
  end

  initial begin : rsp_monitor
    rsp_t e;
    forever begin
      @(negedge sys_clk); #1;
      if (sys_rst_1) begin
        rsp_ready = 1'b0;
      end else begin
        rsp_ready = (rsp_mode == 1) ? 1'b0 : (rsp_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (rsp_valid) begin
          check("one_outstanding", STB_o, 0);
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_rsp", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("rsp_dat", rsp_dat, e.dat);
              check("rsp_flags", {rsp_dup, rsp_timeout}, {e.dup, e.to});
            end
          end
        end
      end
    end
  end

  task automatic push_cmd(input logic we, input logic ak, input logic dk,
                          input logic [15:0] adr, input logic [15:0] dat,
                          input int d, input logic [15:0] rdat, input logic rdup);
    plan_t p;
    rsp_t  e;
    int    b = 0;
    cmd_we = we; cmd_adr_is_key = ak; cmd_dat_is_key = dk;
    cmd_adr = adr; cmd_dat = dat; cmd_valid = 1'b1;
    while (!cmd_ready && b < 300) begin
      @(negedge sys_clk);
      b++;
    end
    if (!cmd_ready) begin
      check("push_accept", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    p.we = we; p.ak = ak; p.dk = dk; p.adr = adr; p.dat = dat;
    p.d = d; p.rdat = rdat; p.rdup = rdup;
    plan_q.push_back(p);
    e.to  = (d > TO);
    e.dat = e.to ? 16'h0 : rdat;
    e.dup = e.to ? 1'b0 : rdup;
    exp_q.push_back(e);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((busy || exp_q.size() != 0) && b < 600) begin
      @(negedge sys_clk);
      b++;
    end
    check("idle_reached", (busy || exp_q.size() != 0), 0);
  endtask

  initial begin : stimulus
    int b;
    cmd_valid = 0; cmd_we = 0; cmd_adr_is_key = 0; cmd_dat_is_key = 0;
    cmd_adr = 0; cmd_dat = 0; ACK_i = 0; DAT_i = 0; DUP_i = 0; rsp_ready = 0;
    #1 sys_rst_1 = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("rst_stb_cyc", {STB_o, CYC_o}, 0);
    check("rst_bus", {WE_o, ADR_IS_KEY_o, DAT_IS_KEY_o, ADR_o, DAT_o}, 0);
    check("rst_rsp", {rsp_valid, rsp_dup, rsp_timeout, rsp_dat}, 0);
    check("rst_ready_busy", {cmd_ready, busy}, 2'b10);
    sys_rst_1 = 1'b0;
    @(negedge sys_clk);

    push_cmd(0, 0, 0, 16'h0012, 16'h0000, 3, 16'hBEEF, 0);
    wait_idle();
    push_cmd(1, 0, 1, 16'h0040, 16'h1234, 2, 16'h5555, 1);
    wait_idle();
    push_cmd(0, 1, 0, 16'h0077, 16'h0001, TO + 5, 16'hDEAD, 1);
    push_cmd(0, 0, 0, 16'h0078, 16'h0002, 1, 16'h0A0A, 0);
    wait_idle();

    for (int i = 1; i <= 5; i++)
      push_cmd(0, 0, 0, 16'(i), 16'(i * 3), TO, 16'(16'h0100 + i), 1'(i));
    check("full_after_5", cmd_ready, 0);
    wait_idle();

    rsp_mode = 1;
    push_cmd(0, 0, 0, 16'h0201, 16'h0000, 1, 16'h1111, 0);
    push_cmd(1, 1, 1, 16'h0202, 16'h0003, 1, 16'h2222, 1);
    b = 0;
    while (!rsp_valid && b < 50) begin
      @(negedge sys_clk);
      b++;
    end
    repeat (10) @(negedge sys_clk);
    check("stall_no_stb", STB_o, 0);
    check("stall_rsp_held", rsp_valid, 1);
    rsp_mode = 2;
    @(negedge sys_clk);
    check("stall_after_hs", {rsp_valid, STB_o}, 0);
    @(negedge sys_clk);
    check("stall_reissue", STB_o, 1);
    rsp_mode = 0;
    wait_idle();

    repeat (60) begin
      repeat ($urandom_range(0, 3)) @(negedge sys_clk);
      push_cmd(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
               $urandom_range(1, TO + 3), 16'($urandom), 1'($urandom));
    end
    wait_idle();

    for (int i = 0; i < 4; i++)
      push_cmd(0, 0, 0, 16'(16'h0300 + i), 16'h0000, 1000, 16'h0000, 0);
    check("reset_setup_stb", STB_o, 1);
    #3 sys_rst_1 = 1'b1;
    #1;
    check("midbus_rst_stb", {STB_o, CYC_o}, 0);
    check("midbus_rst_busy", busy, 0);
    check("midbus_rst_ready", cmd_ready, 1);
    plan_q.delete();
    exp_q.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst_1 = 1'b0;
    late_ack = 1'b1;
    repeat (4) begin
      @(negedge sys_clk);
      check("late_ack_ignored", {rsp_valid, STB_o, busy}, 0);
    end
    late_ack = 1'b0;

    push_cmd(0, 1, 1, 16'hCAFE, 16'h0009, 1, 16'h4321, 1);
    wait_idle();
    check("drain", plan_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

endmodule
